// File: rtl/alarm_setter_if.sv
// Signal bundle between the alarm front end and its surroundings (buttons,
// enable, clock-core alarm flag in; programmed alarm time, status and buzzer out).
//
// Transfer semantics: there is no valid/ready pair on this bundle. Every input
// is a level sampled on each rising clk edge. Every output is a level except
// alarm_clr, which is a strobe: it is high for exactly one cycle and the
// clock core must clear its alarm flag on any cycle where it sees it high.
interface alarm_setter_if;
    logic       ena;
    logic       btn_mode;
    logic       btn_inc;
    logic       alarm_in;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_armed;
    logic       setting_hours;
    logic       setting_mins;
    logic       buzzer;
    logic       alarm_clr;
    logic [1:0] state_dbg;

    modport master (
        output ena, btn_mode, btn_inc, alarm_in,
        input  alarm_hours, alarm_minutes, alarm_armed, setting_hours,
        input  setting_mins, buzzer, alarm_clr, state_dbg
    );

    modport slave (
        input  ena, btn_mode, btn_inc, alarm_in,
        output alarm_hours, alarm_minutes, alarm_armed, setting_hours,
        output setting_mins, buzzer, alarm_clr, state_dbg
    );
endinterface

// File: rtl/alarm_setter.sv
// Alarm clock user front end: debounces the mode/inc buttons, lets the user
// program and arm the alarm time, drives a pulsed buzzer while the clock core
// flags the alarm, and sends a one-cycle clear back to the core on dismissal
// or ring timeout.
module alarm_setter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_PERIOD     = 2,
    parameter int RING_CYCLES     = 60
) (
    input logic           clk,
    input logic           rst_n,
    alarm_setter_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BEEP_PERIOD + 1);
    localparam int RW = $clog2(RING_CYCLES + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_PERIOD - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        RING  = 2'd3
    } state_t;

    // Bit 0 is the mode button, bit 1 the increment button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db_level;
    logic [1:0]    db_q;
    logic [CW-1:0] db_cnt [2];

    logic mode_ev;
    logic inc_ev;
    logic alarm_in_q;
    logic alarm_rise;

    state_t        state;
    logic [RW-1:0] ring_cnt;
    logic [BW-1:0] beep_cnt;
    logic          buzz_phase;
    logic          clr_q;
    logic [4:0]    hours_q;
    logic [5:0]    mins_q;
    logic          armed_q;
    logic          set_h_q;
    logic          set_m_q;

    assign raw = {bus.btn_inc, bus.btn_mode};

    // Two-flop synchronizers; they keep sampling even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new button level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else if (bus.ena) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_level[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Edge-detect history; updated every cycle so edges seen while disabled are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q       <= '0;
            alarm_in_q <= 1'b0;
        end else begin
            db_q       <= db_level;
            alarm_in_q <= bus.alarm_in;
        end
    end

    assign mode_ev    = db_level[0] & ~db_q[0];
    assign inc_ev     = db_level[1] & ~db_q[1];
    assign alarm_rise = bus.alarm_in & ~alarm_in_q;

    // Main control FSM with registered outputs; mode beats inc, a rising alarm beats both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            beep_cnt   <= '0;
            buzz_phase <= 1'b0;
            clr_q      <= 1'b0;
            hours_q    <= '0;
            mins_q     <= '0;
            armed_q    <= 1'b0;
            set_h_q    <= 1'b0;
            set_m_q    <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            if (bus.ena) begin
                case (state)
                    IDLE: begin
                        if (alarm_rise && armed_q) begin
                            state      <= RING;
                            ring_cnt   <= '0;
                            beep_cnt   <= '0;
                            buzz_phase <= 1'b1;
                        end else if (mode_ev) begin
                            state   <= SET_H;
                            set_h_q <= 1'b1;
                        end else if (inc_ev) begin
                            armed_q <= ~armed_q;
                        end
                    end
                    SET_H: begin
                        if (mode_ev) begin
                            state   <= SET_M;
                            set_h_q <= 1'b0;
                            set_m_q <= 1'b1;
                        end else if (inc_ev) begin
                            hours_q <= (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                        end
                    end
                    SET_M: begin
                        if (mode_ev) begin
                            state   <= IDLE;
                            set_m_q <= 1'b0;
                            armed_q <= 1'b1;
                        end else if (inc_ev) begin
                            mins_q <= (mins_q == 6'd59) ? 6'd0 : mins_q + 6'd1;
                        end
                    end
                    RING: begin
                        // Timeout and a press exit identically, so no priority is needed.
                        if (ring_cnt == RING_LAST || mode_ev || inc_ev) begin
                            state      <= IDLE;
                            ring_cnt   <= '0;
                            beep_cnt   <= '0;
                            buzz_phase <= 1'b0;
                            clr_q      <= 1'b1;
                        end else begin
                            ring_cnt <= ring_cnt + RW'(1);
                            if (beep_cnt == BEEP_LAST) begin
                                beep_cnt   <= '0;
                                buzz_phase <= ~buzz_phase;
                            end else begin
                                beep_cnt <= beep_cnt + BW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Disable silences the buzzer and strobe without disturbing the beep phase.
    assign bus.buzzer        = buzz_phase & bus.ena;
    assign bus.alarm_clr     = clr_q & bus.ena;
    assign bus.alarm_hours   = hours_q;
    assign bus.alarm_minutes = mins_q;
    assign bus.alarm_armed   = armed_q;
    assign bus.setting_hours = set_h_q;
    assign bus.setting_mins  = set_m_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_alarm_setter.sv
// Bench for alarm_setter: a behavioural model predicts every change of the
// output vector (value and cycle) into exp_q when stimulus is issued; a
// monitor pops and compares whenever the DUT outputs change.
module tb_alarm_setter;
    localparam int D  = 4;
    localparam int BP = 2;
    localparam int RC = 60;

    logic clk;
    logic rst_n;
    int   cyc;

    alarm_setter_if bus ();

    alarm_setter #(
        .DEBOUNCE_CYCLES(D),
        .BEEP_PERIOD    (BP),
        .RING_CYCLES    (RC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Clock, cycle counter and reset drive
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // Scoreboard state: {cycle[31:0], output vector[15:0]}
    logic [47:0] exp_q[$];
    logic [15:0] last_pushed;
    logic [15:0] prev;
    bit          mon_en;
    int          n_checks;
    int          n_fail;

    // Reference model state
    int m_hours;
    int m_mins;
    bit m_armed;
    int m_mode;   // 0 idle, 1 setting hours, 2 setting minutes

    function automatic logic [15:0] dut_vec();
        return {bus.alarm_hours, bus.alarm_minutes, bus.alarm_armed,
                bus.setting_hours, bus.setting_mins, bus.buzzer, bus.alarm_clr};
    endfunction

    function automatic logic [15:0] snap(input bit buz, input bit clr);
        return {5'(m_hours), 6'(m_mins), m_armed, (m_mode == 1), (m_mode == 2), buz, clr};
    endfunction

    task automatic push(input int t, input logic [15:0] v);
        if (v != last_pushed) begin
            exp_q.push_back({32'(t), v});
            last_pushed = v;
        end
    endtask

    task automatic model_press(input int t, input bit m, input bit i);
        if (m) begin
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1) m_mode = 2;
            else begin
                m_mode  = 0;
                m_armed = 1'b1;
            end
        end else if (i) begin
            if (m_mode == 0) m_armed = !m_armed;
            else if (m_mode == 1) m_hours = (m_hours + 1) % 24;
            else m_mins = (m_mins + 1) % 60;
        end
        push(t, snap(1'b0, 1'b0));
    endtask

    // Monitor: compare on every output change, flag predictions that never showed up
    always begin
        logic [15:0] cur;
        logic [47:0] e;
        @(posedge clk);
        #2;
        if (mon_en) begin
            cur = dut_vec();
            while (exp_q.size() > 0 && int'(exp_q[0][47:16]) < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_change: required %h at cycle %0d, outputs still %h at cycle %0d",
                         e[15:0], int'(e[47:16]), cur, cyc);
            end
            if (cur != prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, required no change from %h",
                             cur, cyc, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(e[47:16]) != cyc || e[15:0] != cur) begin
                        n_fail++;
                        $display("FAIL output_change: got %h at cycle %0d, required %h at cycle %0d",
                                 cur, cyc, e[15:0], int'(e[47:16]));
                    end
                end
                prev = cur;
            end
        end
    end

    // Driver tasks
    task automatic press_drive(input bit m, input bit i, input int hold);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        repeat (hold) @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
    endtask

    task automatic press(input bit m, input bit i, input int hold, input int gap);
        @(negedge clk);
        if (hold >= D) model_press(cyc + D + 3, m, i);
        press_drive(m, i, hold);
        repeat (gap) @(negedge clk);
    endtask

    task automatic qpress(input bit m, input bit i);
        press(m, i, D, D + 3);
    endtask

    // how: 0 timeout (optional enable pause), 1 dismiss with inc, 2 dismiss with mode
    task automatic ring(input int how, input int dly, input int poff, input int plen,
                        input bit keep_high);
        int e_t;
        int x_t;
        int j;
        bit en;
        @(negedge clk);
        e_t = cyc + 1;
        bus.alarm_in = 1'b1;
        x_t = (how != 0) ? e_t + dly + D + 2 : 0;
        j = 0;
        for (int t = e_t; t < e_t + 1000; t++) begin
            en = !(plen > 0 && t >= e_t + poff + 1 && t <= e_t + poff + plen);
            if (t > e_t && en) j++;
            if ((how == 0 && j == RC) || (how != 0 && t == x_t)) begin
                x_t = t;
                break;
            end
            push(t, snap(en && ((j / BP) % 2 == 0), 1'b0));
        end
        push(x_t, snap(1'b0, 1'b1));
        push(x_t + 1, snap(1'b0, 1'b0));
        if (how != 0) begin
            repeat (dly) @(negedge clk);
            press_drive(how == 2, how == 1, D + 2);
        end else if (plen > 0) begin
            repeat (poff + 1) @(negedge clk);
            bus.ena = 1'b0;
            repeat (plen) @(negedge clk);
            bus.ena = 1'b1;
        end
        while (cyc < x_t + 3) @(negedge clk);
        if (!keep_high) bus.alarm_in = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic alarm_pulse(input int len);
        @(negedge clk);
        bus.alarm_in = 1'b1;
        repeat (len) @(negedge clk);
        bus.alarm_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic disabled_press(input bit m);
        @(negedge clk);
        bus.ena = 1'b0;
        repeat (2) @(negedge clk);
        press_drive(m, !m, D + 3);
        repeat (D + 3) @(negedge clk);
        bus.ena = 1'b1;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        mon_en       = 1'b0;
        rst_n        = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.alarm_in = 1'b0;
        bus.ena      = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, required 0000", dut_vec());
        end
        exp_q.delete();
        m_hours     = 0;
        m_mins      = 0;
        m_armed     = 1'b0;
        m_mode      = 0;
        last_pushed = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        prev   = dut_vec();
        mon_en = 1'b1;
    endtask

    // Stimulus sequence
    initial begin
        int e_t;
        int op;
        rst_n        = 1'b0;
        bus.ena      = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.alarm_in = 1'b0;
        mon_en       = 1'b0;
        n_checks     = 0;
        n_fail       = 0;
        async_reset();

        // Held mode press enters hour setting; short inc glitch does nothing
        press(1'b1, 1'b0, 10, D + 4);
        press(1'b0, 1'b1, 3, D + 4);

        // Program 23:02, then wrap hours to 0 and minutes through 59 -> 0
        repeat (23) qpress(1'b0, 1'b1);
        qpress(1'b1, 1'b0);
        repeat (2) qpress(1'b0, 1'b1);
        qpress(1'b1, 1'b0);
        qpress(1'b1, 1'b0);
        qpress(1'b0, 1'b1);
        qpress(1'b1, 1'b0);
        repeat (59) qpress(1'b0, 1'b1);
        qpress(1'b1, 1'b0);

        // Ring dismissed by inc; ring timeout with alarm_in held high afterwards
        ring(1, 7, 0, 0, 1'b0);
        ring(0, 0, 0, 0, 1'b1);
        repeat (20) @(negedge clk);
        bus.alarm_in = 1'b0;
        repeat (4) @(negedge clk);

        // Simultaneous buttons in idle; alarm rising during minute setting is ignored
        press(1'b1, 1'b1, D + 2, D + 4);
        qpress(1'b1, 1'b0);
        @(negedge clk);
        bus.alarm_in = 1'b1;
        repeat (5) @(negedge clk);
        qpress(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        bus.alarm_in = 1'b0;
        repeat (4) @(negedge clk);

        // Enable pause mid-ring, presses while disabled, reset mid-ring and mid-SET_M
        ring(0, 0, 5, 6, 1'b0);
        disabled_press(1'b0);
        disabled_press(1'b1);
        @(negedge clk);
        e_t = cyc + 1;
        bus.alarm_in = 1'b1;
        for (int t = e_t; t <= e_t + 5; t++) push(t, snap(((t - e_t) / BP) % 2 == 0, 1'b0));
        repeat (5) @(negedge clk);
        async_reset();
        qpress(1'b1, 1'b0);
        qpress(1'b0, 1'b1);
        qpress(1'b1, 1'b0);
        qpress(1'b0, 1'b1);
        async_reset();

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: press(1'b1, 1'b0, $urandom_range(D, D + 6), $urandom_range(D + 3, D + 8));
                1: press(1'b0, 1'b1, $urandom_range(D, D + 6), $urandom_range(D + 3, D + 8));
                2: press(1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, D - 1), D + 3);
                3: if (m_mode == 0 && m_armed) ring($urandom_range(1, 2), $urandom_range(1, 45), 0, 0, 1'b0);
                   else alarm_pulse($urandom_range(1, 5));
                4: if (m_mode == 0 && m_armed) ring(0, 0, $urandom_range(0, 30), $urandom_range(0, 10), 1'b0);
                   else alarm_pulse($urandom_range(1, 5));
                default: disabled_press(1'($urandom_range(0, 1)));
            endcase
        end

        // Final report
        repeat (10) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations: got %0d left in queue, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
